// File: rtl/dispatch_if.sv
// Decode-side and back-end-side signals of the dispatch scheduler.
// The master modport is the pipeline around the scheduler; the slave modport is the scheduler itself.
interface dispatch_if #(
    parameter int NUM_CLASS = 5,
    parameter int PAYLOAD_W = 256,
    parameter int TAG_W     = 4
);
    logic                 flush;
    logic                 in_valid;
    logic [2:0]           in_type;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 stall;
    logic [NUM_CLASS-1:0] disp_valid;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [TAG_W-1:0]     disp_rob_tag;
    logic                 rob_alloc;
    logic [NUM_CLASS-1:0] rs_free;
    logic                 rob_commit;
    logic                 err_overflow;

    modport master (
        output flush, in_valid, in_type, in_payload, rs_free, rob_commit,
        input  stall, disp_valid, disp_payload, disp_rob_tag, rob_alloc, err_overflow
    );

    modport slave (
        input  flush, in_valid, in_type, in_payload, rs_free, rob_commit,
        output stall, disp_valid, disp_payload, disp_rob_tag, rob_alloc, err_overflow
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler: holds one decoded instruction and issues it to the RS of its class
// once that RS and the ROB both have credit; tracks the credits and hands out ROB tags.
module dispatch_ctrl #(
    parameter int NUM_CLASS = 5,
    parameter int RS_DEPTH  = 4,
    parameter int ROB_DEPTH = 16,
    parameter int PAYLOAD_W = 256
) (
    input logic       clk,
    input logic       rst,
    dispatch_if.slave bus
);
    // state   | meaning
    // S_EMPTY | no instruction held
    // S_HOLD  | instruction held, issues when RS and ROB credit allow

    localparam int TAG_W  = $clog2(ROB_DEPTH);
    localparam int CRED_W = $clog2(RS_DEPTH + 1);
    localparam int ROBC_W = $clog2(ROB_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_FULL   = CRED_W'(RS_DEPTH);
    localparam logic [ROBC_W-1:0] ROBC_FULL   = ROBC_W'(ROB_DEPTH);
    localparam logic [TAG_W-1:0]  TAG_LAST    = TAG_W'(ROB_DEPTH - 1);
    localparam logic [2:0]        NUM_CLASS_T = 3'(NUM_CLASS);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t               state, state_nxt;
    logic [2:0]           hold_type;
    logic [PAYLOAD_W-1:0] hold_payload;
    logic [CRED_W-1:0]    credit [NUM_CLASS];
    logic [ROBC_W-1:0]    rob_credit;
    logic [TAG_W-1:0]     tail;
    logic                 err;
    logic                 fire, stall_i, accept, load;
    logic [NUM_CLASS-1:0] dv, rs_inc, rs_ovf;
    logic                 rob_inc, rob_ovf;

    always_comb begin
        fire      = (state == S_HOLD) && (credit[hold_type] != '0) &&
                    (rob_credit != '0) && !bus.flush;
        stall_i   = (state == S_HOLD) && !fire;
        accept    = bus.in_valid && !stall_i && !bus.flush;
        // Out-of-range classes are accepted but never loaded, so they vanish without a dispatch.
        load      = accept && (bus.in_type < NUM_CLASS_T);
        dv        = '0;
        if (fire) dv[hold_type] = 1'b1;
        for (int c = 0; c < NUM_CLASS; c++) begin
            rs_ovf[c] = bus.rs_free[c] && !dv[c] && (credit[c] == CRED_FULL);
            rs_inc[c] = bus.rs_free[c] && !rs_ovf[c];
        end
        rob_ovf   = bus.rob_commit && !fire && (rob_credit == ROBC_FULL);
        rob_inc   = bus.rob_commit && !rob_ovf;
        state_nxt = state;
        if (bus.flush)  state_nxt = S_EMPTY;
        else if (load)  state_nxt = S_HOLD;
        else if (fire)  state_nxt = S_EMPTY;
    end

    assign bus.stall        = stall_i;
    assign bus.disp_valid   = dv;
    assign bus.rob_alloc    = fire;
    assign bus.disp_payload = fire ? hold_payload : '0;
    assign bus.disp_rob_tag = tail;
    assign bus.err_overflow = err;

    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_type    <= '0;
            hold_payload <= '0;
        end else if (load) begin
            hold_type    <= bus.in_type;
            hold_payload <= bus.in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int c = 0; c < NUM_CLASS; c++) credit[c] <= CRED_FULL;
            rob_credit <= ROBC_FULL;
            tail       <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++)
                credit[c] <= credit[c] + CRED_W'(rs_inc[c]) - CRED_W'(dv[c]);
            rob_credit <= rob_credit + ROBC_W'(rob_inc) - ROBC_W'(fire);
            if (fire) tail <= (tail == TAG_LAST) ? '0 : tail + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                       err <= 1'b0;
        else if (!bus.flush && ((|rs_ovf) || rob_ovf)) err <= 1'b1;
    end
endmodule
